// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// The stage drives a word-aligned PC into a synchronous instruction memory
// (data returns one cycle after the request). Each returned word is stored
// together with its PC. Decode takes the head entry over a valid/ready
// handshake. A redirect flushes the queue and restarts fetch.
//
// Ports
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   imem_req/addr  : memory read request and byte address (always word aligned)
//   imem_rdata     : memory read data, valid the cycle after a request
//   redirect/_addr : flush and restart fetch at redirect_addr (bits [1:0] ignored)
//   ins_valid/ready: decode handshake for the head entry
//   ins_data/pc    : head instruction and its byte PC
//   fq_count       : number of occupied queue entries
module if_fetch_queue #(
  parameter int WIDTH = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [WIDTH-1:0]           imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic                       ins_valid,
  input  logic                       ins_ready,
  output logic [WIDTH-1:0]           ins_data,
  output logic [ADDR_W-1:0]          ins_pc,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] mem_pc_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc_d [DEPTH];
  logic [WIDTH-1:0]  mem_data_q [DEPTH];
  logic [WIDTH-1:0]  mem_data_d [DEPTH];

  logic              valid_s;
  logic              pop_s;
  logic              wr_s;
  logic              req_s;
  logic [CW:0]       occ_s;
  logic              redirect_lsb_unused_s;

  // The low address bits of a redirect target are dropped on purpose.
  assign redirect_lsb_unused_s = ^redirect_addr[1:0];

  // Handshake, response-write and credit-based request decisions.
  always_comb begin
    valid_s = (count_q != {CW{1'b0}});
    pop_s   = valid_s & ins_ready & ~redirect;
    wr_s    = inflight_q & ~redirect;
    // Occupancy after this cycle's pop, counting the response still in flight:
    // a new request is only issued if its response is guaranteed a free slot.
    occ_s   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
    req_s   = ~rst & ~redirect & (occ_s < DEPTH_C);
  end

  // Next-state logic for fetch PC, in-flight tracking, pointers and count.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      // Flush: pending response and any handshake this cycle are discarded.
      fetch_pc_d = {redirect_addr[ADDR_W-1:2], 2'b00};
      inflight_d = 1'b0;
      wr_ptr_d   = {PW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      count_d    = {CW{1'b0}};
    end else begin
      if (req_s) begin
        fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else begin
        inflight_d = 1'b0;
      end
      if (wr_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue storage next state: the returning word is written with its PC.
  always_comb begin
    mem_pc_d   = mem_pc_q;
    mem_data_d = mem_data_q;
    if (wr_s) begin
      mem_pc_d[wr_ptr_q]   = inflight_pc_q;
      mem_data_d[wr_ptr_q] = imem_rdata;
    end else begin
      mem_pc_d   = mem_pc_q;
      mem_data_d = mem_data_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      count_q       <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_pc_q      <= mem_pc_d;
      mem_data_q    <= mem_data_d;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_q;
  assign ins_valid = valid_s;
  assign ins_data  = mem_data_q[rd_ptr_q];
  assign ins_pc    = mem_pc_q[rd_ptr_q];
  assign fq_count  = count_q;

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a prefetch queue. It drives the word-aligned PC into the synchronous instruction memory and buffers returned instructions, each tagged with its PC, in a DEPTH-entry FIFO. Instructions are handed to decode over a valid/ready handshake, and the block supports redirects for branches and jumps. It replaces the single-register fetch stage between IMem and decode, adding back-pressure, buffering and width/depth generality.

## Interface
- WIDTH, 32, instruction width in bits
- ADDR_W, 32, byte-address width of the PC
- DEPTH, 4, number of fetch-queue entries; power of 2, at least 2
- RESET_PC, 0, fetch address after reset; word aligned
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- imem_req  output  1  read request this cycle; the memory always accepts it
- imem_addr  output  ADDR_W  byte address of the request; bits [1:0] are always 0
- imem_rdata  input  WIDTH  read data, valid exactly 1 cycle after an accepted request
- redirect  input  1  flush the queue and restart fetch at redirect_addr
- redirect_addr  input  ADDR_W  new fetch address; bits [1:0] are ignored and treated as 0
- ins_valid  output  1  queue head holds a valid instruction
- ins_ready  input  1  decode accepts the head this cycle
- ins_data  output  WIDTH  head instruction
- ins_pc  output  ADDR_W  byte PC of the head instruction
- fq_count  output  $clog2(DEPTH+1)  number of occupied entries

## Operation
- State:
  - fetch_pc register.
  - inflight bit: a request was issued last cycle.
  - inflight_pc register.
  - Circular queue with read/write pointers and a count; each entry holds {pc, data}.
- pop = ins_valid & ins_ready & ~redirect.
- Request rule: imem_req = ~rst & ~redirect & (fq_count + inflight - pop < DEPTH). This credit check guarantees every response has a free slot.
  - imem_addr = fetch_pc at all times.
- On an issued request:
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W.
  - inflight <= 1 and inflight_pc <= fetch_pc.
  - Otherwise inflight <= 0.
- Response: when inflight=1 and redirect=0, write {inflight_pc, imem_rdata} at the write pointer.
- Count update: fq_count changes by (+1 on write) (-1 on pop). Simultaneous write and pop leaves the count unchanged.
- ins_valid = (fq_count != 0). ins_data and ins_pc come from the head entry.
- Redirect cycle:
  - Queue flushed: pointers and count go to 0.
  - Any response arriving this cycle is discarded.
  - Any ins_valid&ins_ready handshake this cycle does not count.
  - No request is issued.
  - fetch_pc <= {redirect_addr[ADDR_W-1:2], 2'b00}.
- Redirect has priority over every other event. rst has priority over redirect.
- Reset, same cycle rst is high:
  - fetch_pc=RESET_PC, inflight=0, pointers=0, fq_count=0.
  - Entry 0 is cleared, so ins_data=0 and ins_pc=0.
  - ins_valid=0, imem_req=0, imem_addr=RESET_PC.
  - Reset asserted mid-stream discards the queue and any inflight response.
- Full queue: with ready low, requests stop once fq_count + inflight reaches DEPTH. imem_addr holds and nothing is overwritten.
- Empty queue: ins_valid=0. ins_ready is ignored.
- Queue pointers wrap modulo DEPTH.

## Timing
- Cycle 0 is the first cycle with rst low: imem_req=1, imem_addr=RESET_PC.
- Cycle 1: data returns and is written at the edge.
- Cycle 2: ins_valid=1, ins_pc=RESET_PC. Load-to-use latency is 2 cycles.
- Steady state with ins_ready held high is 1 instruction per cycle, with no bubbles.
- Redirect asserted in cycle T: request at redirect_addr in T+1; ins_valid=1 with that PC in T+3. Cycles T+1 and T+2 show ins_valid=0.
- After back-pressure releases, the first request issues in the same cycle as the first pop.

## Test plan
- Reset release with DEPTH=4, IMem word n = n, ready held high:
  - ins_valid rises in cycle 2.
  - ins_pc sequence is 0,4,8,12,…; ins_data is 0,1,2,3,….
  - One instruction per cycle, and fq_count stays at 1 or below.
- ins_ready low from cycle 0:
  - fq_count saturates at 4 with imem_req=0 and imem_addr=0x10.
  - Raising ready drains PCs 0,4,8,12, then 0x10 follows with no gap and no loss.
- Redirect to 0x103 in a cycle where a response is inflight and ins_ready=1:
  - The response is dropped and no pop occurs; fq_count=0 next cycle.
  - imem_addr=0x100 in T+1; next ins_pc=0x100 in T+3.
- Redirect and rst asserted together mid-stream:
  - Reset wins: imem_addr=RESET_PC, fq_count=0, ins_valid=0, ins_data=0, ins_pc=0.
- ADDR_W=8, RESET_PC=0xF8, ready high:
  - PCs are 0xF8, 0xFC, 0x00, 0x04 (wrap-around).
  - Random ready toggling across 100 cycles keeps the sequence gap-free and in order.
